// File: rtl/cordic_rotation_sequencer_if.sv
// Signal bundle between the CORDIC sequencer (slave) and its environment (master):
// two requesters, the result consumer and the iterative rotation engine.
interface cordic_rotation_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 18
);
    logic                  i_a_valid;
    logic                  o_a_ready;
    logic [DATA_WIDTH-1:0] i_a_phase;
    logic                  i_b_valid;
    logic                  o_b_ready;
    logic [DATA_WIDTH-1:0] i_b_phase;

    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_cos;
    logic [DATA_WIDTH-1:0] o_sin;
    logic                  o_id;

    logic                  o_eng_rst_n;
    logic                  o_eng_valid;
    logic [DATA_WIDTH-1:0] o_eng_x;
    logic [DATA_WIDTH-1:0] o_eng_y;
    logic [DATA_WIDTH-1:0] o_eng_alpha;
    logic [DATA_WIDTH-1:0] o_eng_atan;
    logic [1:0]            o_eng_quadrant;
    logic                  i_eng_valid;
    logic [DATA_WIDTH-1:0] i_eng_x;
    logic [DATA_WIDTH-1:0] i_eng_y;

    modport slave (
        input  i_a_valid, i_a_phase, i_b_valid, i_b_phase, i_ready,
        input  i_eng_valid, i_eng_x, i_eng_y,
        output o_a_ready, o_b_ready, o_valid, o_cos, o_sin, o_id,
        output o_eng_rst_n, o_eng_valid, o_eng_x, o_eng_y, o_eng_alpha, o_eng_atan,
        output o_eng_quadrant
    );

    modport master (
        output i_a_valid, i_a_phase, i_b_valid, i_b_phase, i_ready,
        output i_eng_valid, i_eng_x, i_eng_y,
        input  o_a_ready, o_b_ready, o_valid, o_cos, o_sin, o_id,
        input  o_eng_rst_n, o_eng_valid, o_eng_x, o_eng_y, o_eng_alpha, o_eng_atan,
        input  o_eng_quadrant
    );
endinterface

// File: rtl/cordic_rotation_sequencer.sv
// Front-end for an iterative CORDIC rotation engine: arbitrates two requesters, reduces the
// phase to a first-quadrant residual, streams atan constants in lock-step, corrects the result.
module cordic_rotation_sequencer #(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned N_PE       = 16,
    parameter int unsigned K_INIT     = 39797
) (
    input logic                        i_clk,
    input logic                        i_rst,
    cordic_rotation_sequencer_if.slave bus
);
    localparam int unsigned      IDX_W    = $clog2(N_PE + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PE);

    typedef enum logic [1:0] {StIdle, StLaunch, StRun, StHold} state_e;

    state_e                state_q, state_d;
    logic                  pri_q, pri_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-3:0] resid_q, resid_d;
    logic [1:0]            quad_q, quad_d;
    logic                  id_q, id_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] cos_q, cos_d;
    logic [DATA_WIDTH-1:0] sin_q, sin_d;
    logic [1:0]            eng_rst_q, eng_rst_d;

    logic                         a_ready, b_ready;
    logic [DATA_WIDTH-1:0]        req_phase;
    logic                         eng_valid;
    logic [DATA_WIDTH-1:0]        eng_x, eng_y, eng_alpha, eng_atan;
    logic signed [DATA_WIDTH-1:0] res_x, res_y;
    logic [DATA_WIDTH-1:0]        corr_cos, corr_sin;

    // atan(2^-k) with a full circle of 2^18; constants assume DATA_WIDTH = 18.
    function automatic logic [DATA_WIDTH-1:0] atan_lut(input int k);
        logic [31:0] v;
        case (k)
            0:       v = 32'd32768;
            1:       v = 32'd19344;
            2:       v = 32'd10221;
            3:       v = 32'd5188;
            4:       v = 32'd2604;
            5:       v = 32'd1303;
            6:       v = 32'd652;
            7:       v = 32'd326;
            8:       v = 32'd163;
            9:       v = 32'd81;
            10:      v = 32'd41;
            11:      v = 32'd20;
            12:      v = 32'd10;
            13:      v = 32'd5;
            14:      v = 32'd3;
            15:      v = 32'd1;
            16:      v = 32'd1;
            default: v = 32'd0;
        endcase
        return v[DATA_WIDTH-1:0];
    endfunction

    // pri_q = 0 favours A on a tie; nothing is granted while the engine is held in reset.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (state_q == StIdle && eng_rst_q[1]) begin
            a_ready = bus.i_a_valid & (~bus.i_b_valid | ~pri_q);
            b_ready = bus.i_b_valid & (~bus.i_a_valid | pri_q);
        end
    end

    always_comb begin
        res_x    = signed'(bus.i_eng_x);
        res_y    = signed'(bus.i_eng_y);
        corr_cos = res_x;
        corr_sin = res_y;
        unique case (quad_q)
            2'd0: begin
                corr_cos = res_x;
                corr_sin = res_y;
            end
            2'd1: begin
                corr_cos = -res_y;
                corr_sin = res_x;
            end
            2'd2: begin
                corr_cos = -res_x;
                corr_sin = -res_y;
            end
            2'd3: begin
                corr_cos = res_y;
                corr_sin = -res_x;
            end
        endcase
    end

    assign req_phase = b_ready ? bus.i_b_phase : bus.i_a_phase;
    assign eng_rst_d = {eng_rst_q[0], 1'b1};

    always_comb begin
        state_d   = state_q;
        pri_d     = pri_q;
        idx_d     = idx_q;
        resid_d   = resid_q;
        quad_d    = quad_q;
        id_d      = id_q;
        valid_d   = valid_q;
        cos_d     = cos_q;
        sin_d     = sin_q;
        eng_valid = 1'b0;
        eng_x     = '0;
        eng_y     = '0;
        eng_alpha = '0;
        eng_atan  = '0;
        unique case (state_q)
            StIdle: begin
                if (a_ready || b_ready) begin
                    resid_d = req_phase[DATA_WIDTH-3:0];
                    quad_d  = req_phase[DATA_WIDTH-1:DATA_WIDTH-2];
                    id_d    = b_ready;
                    pri_d   = ~b_ready;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                eng_valid = 1'b1;
                eng_x     = DATA_WIDTH'(K_INIT);
                eng_alpha = {2'b00, resid_q};
                eng_atan  = atan_lut(0);
                idx_d     = IDX_W'(1);
                state_d   = StRun;
            end
            StRun: begin
                eng_atan = (idx_q < IDX_LAST) ? atan_lut(int'(idx_q)) : '0;
                if (idx_q != IDX_LAST) begin
                    idx_d = idx_q + 1'b1;
                end
                if (bus.i_eng_valid) begin
                    cos_d   = corr_cos;
                    sin_d   = corr_sin;
                    valid_d = 1'b1;
                    idx_d   = '0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (bus.i_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            pri_q     <= 1'b0;
            idx_q     <= '0;
            resid_q   <= '0;
            quad_q    <= '0;
            id_q      <= 1'b0;
            valid_q   <= 1'b0;
            cos_q     <= '0;
            sin_q     <= '0;
            eng_rst_q <= '0;
        end else begin
            state_q   <= state_d;
            pri_q     <= pri_d;
            idx_q     <= idx_d;
            resid_q   <= resid_d;
            quad_q    <= quad_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            cos_q     <= cos_d;
            sin_q     <= sin_d;
            eng_rst_q <= eng_rst_d;
        end
    end

    assign bus.o_a_ready      = a_ready;
    assign bus.o_b_ready      = b_ready;
    assign bus.o_valid        = valid_q;
    assign bus.o_cos          = cos_q;
    assign bus.o_sin          = sin_q;
    assign bus.o_id           = id_q;
    assign bus.o_eng_rst_n    = eng_rst_q[1];
    assign bus.o_eng_valid    = eng_valid;
    assign bus.o_eng_x        = eng_x;
    assign bus.o_eng_y        = eng_y;
    assign bus.o_eng_alpha    = eng_alpha;
    assign bus.o_eng_atan     = eng_atan;
    assign bus.o_eng_quadrant = quad_q;
endmodule

// File: tb/tb_cordic_rotation_sequencer.sv
// Bench for cordic_rotation_sequencer with a behavioural iterative CORDIC engine attached.
module tb_cordic_rotation_sequencer;
    localparam int DW  = 18;
    localparam int NPE = 16;
    localparam int KI  = 39797;
    localparam int TOL = 8;
    localparam int F   = 16;

    typedef struct {
        logic          sel_b;
        logic [DW-1:0] phase;
        int            exp_cos;
        int            exp_sin;
    } vec_t;

    logic   clk       = 1'b0;
    logic   rst       = 1'b0;
    int     total     = 0;
    int     bad       = 0;
    bit     both_seen = 1'b0;
    int     lut_exp [17] = '{32768, 19344, 10221, 5188, 2604, 1303, 652, 326, 163, 81, 41, 20,
                             10, 5, 3, 1, 0};
    vec_t   vecs [8];
    longint mx, my;
    int     mz, mcnt;
    bit     mbusy;

    always #5 clk = ~clk;

    cordic_rotation_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    cordic_rotation_sequencer #(
        .DATA_WIDTH(DW),
        .N_PE      (NPE),
        .K_INIT    (KI)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    // Engine stand-in: samples the launch at E1, one iteration per edge, result valid after E(N+1).
    task automatic eng_step(input int k, input int atan);
        longint dx, dy;
        dx = mx >>> k;
        dy = my >>> k;
        if (mz >= 0) begin
            mx = mx - dy;
            my = my + dx;
            mz = mz - atan;
        end else begin
            mx = mx + dy;
            my = my - dx;
            mz = mz + atan;
        end
    endtask

    always @(posedge clk) begin
        if (!bus.o_eng_rst_n) begin
            mbusy = 1'b0;
            mcnt  = 0;
            bus.i_eng_valid <= 1'b0;
            bus.i_eng_x     <= '0;
            bus.i_eng_y     <= '0;
        end else begin
            bus.i_eng_valid <= 1'b0;
            if (mbusy) begin
                if (mcnt < NPE) begin
                    eng_step(mcnt, int'(bus.o_eng_atan));
                    mcnt++;
                end else begin
                    bus.i_eng_valid <= 1'b1;
                    bus.i_eng_x     <= DW'((mx + 64'sd32768) >>> F);
                    bus.i_eng_y     <= DW'((my + 64'sd32768) >>> F);
                    mbusy = 1'b0;
                end
            end else if (bus.o_eng_valid) begin
                mx = longint'(signed'(bus.o_eng_x)) <<< F;
                my = longint'(signed'(bus.o_eng_y)) <<< F;
                mz = int'(bus.o_eng_alpha);
                eng_step(0, int'(bus.o_eng_atan));
                mcnt  = 1;
                mbusy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.o_a_ready && bus.o_b_ready) both_seen = 1'b1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_near(input string name, input longint act, input longint exp);
        total++;
        if (act > exp + TOL || act < exp - TOL) begin
            bad++;
            $display("FAIL %s: got %0d want %0d +/-%0d", name, act, exp, TOL);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input logic sel_b);
        int w = 0;
        while (!(sel_b ? bus.o_b_ready : bus.o_a_ready) && w < 50) begin
            tick();
            w++;
        end
        chk("request accepted", sel_b ? bus.o_b_ready : bus.o_a_ready, 1);
    endtask

    task automatic run_job(input logic sel_b, input logic [DW-1:0] ph, input bit watch,
                           output int cosv, output int sinv, output int idv, output int lat);
        if (sel_b) begin
            bus.i_b_valid = 1'b1;
            bus.i_b_phase = ph;
        end else begin
            bus.i_a_valid = 1'b1;
            bus.i_a_phase = ph;
        end
        #1;
        wait_ready(sel_b);
        tick();
        bus.i_a_valid = 1'b0;
        bus.i_b_valid = 1'b0;
        if (watch) begin
            chk("launch eng_valid", bus.o_eng_valid, 1);
            chk("launch eng_x", bus.o_eng_x, KI);
            chk("launch eng_y", bus.o_eng_y, 0);
            chk("launch alpha", bus.o_eng_alpha, ph[DW-3:0]);
            chk("launch quadrant", bus.o_eng_quadrant, ph[DW-1:DW-2]);
            chk("launch atan", bus.o_eng_atan, lut_exp[0]);
        end
        lat = 0;
        while (!bus.o_valid && lat < 40) begin
            if (watch && lat == 1) chk("eng_valid single cycle", bus.o_eng_valid, 0);
            if (watch && lat >= 1 && lat <= NPE + 1)
                chk($sformatf("atan idx %0d", lat), bus.o_eng_atan,
                    lut_exp[lat < NPE ? lat : NPE]);
            tick();
            lat++;
        end
        chk("o_valid", bus.o_valid, 1);
        cosv = int'(signed'(bus.o_cos));
        sinv = int'(signed'(bus.o_sin));
        idv  = int'(bus.o_id);
        if (bus.i_ready) begin
            tick();
            chk("o_valid drops after handshake", bus.o_valid, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int c, s, id, lat, w;
        bit stable, stale;

        vecs[0] = '{1'b0, 18'h00000,  65536,      0};
        vecs[1] = '{1'b1, 18'h10000,      0,  65536};
        vecs[2] = '{1'b0, 18'h20000, -65536,      0};
        vecs[3] = '{1'b1, 18'h2AAAB, -32768, -56756};
        vecs[4] = '{1'b0, 18'h30000,      0, -65536};
        vecs[5] = '{1'b1, 18'h08000,  46341,  46341};
        vecs[6] = '{1'b0, 18'h05555,  56756,  32768};
        vecs[7] = '{1'b1, 18'h38000,  46341, -46341};

        bus.i_a_valid = 1'b0;
        bus.i_b_valid = 1'b0;
        bus.i_a_phase = '0;
        bus.i_b_phase = '0;
        bus.i_ready   = 1'b1;
        #1 rst = 1'b1;
        tick();
        tick();
        chk("reset o_valid", bus.o_valid, 0);
        chk("reset o_cos", bus.o_cos, 0);
        chk("reset o_sin", bus.o_sin, 0);
        chk("reset o_id", bus.o_id, 0);
        chk("reset eng_rst_n", bus.o_eng_rst_n, 0);
        chk("reset eng_valid", bus.o_eng_valid, 0);
        chk("reset eng_atan", bus.o_eng_atan, 0);
        chk("reset eng_quadrant", bus.o_eng_quadrant, 0);

        rst = 1'b0;
        bus.i_a_valid = 1'b1;
        #1;
        chk("eng_rst_n after release", bus.o_eng_rst_n, 0);
        chk("no accept in engine reset", bus.o_a_ready, 0);
        tick();
        chk("eng_rst_n edge 1", bus.o_eng_rst_n, 0);
        chk("no accept edge 1", bus.o_a_ready, 0);
        tick();
        chk("eng_rst_n edge 2", bus.o_eng_rst_n, 1);
        bus.i_a_valid = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i].sel_b, vecs[i].phase, i == 0, c, s, id, lat);
            chk_near($sformatf("vec%0d cos", i), c, vecs[i].exp_cos);
            chk_near($sformatf("vec%0d sin", i), s, vecs[i].exp_sin);
            chk($sformatf("vec%0d id", i), id, vecs[i].sel_b);
            chk($sformatf("vec%0d latency", i), lat, NPE + 2);
        end

        // Both requesters held: grants must alternate starting with A.
        bus.i_a_phase = 18'h00000;
        bus.i_b_phase = 18'h20000;
        bus.i_a_valid = 1'b1;
        bus.i_b_valid = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            w = 0;
            while (!(bus.o_a_ready || bus.o_b_ready) && w < 50) begin
                tick();
                w++;
            end
            chk($sformatf("grant %0d b_ready", g), bus.o_b_ready, g % 2);
            chk($sformatf("grant %0d a_ready", g), bus.o_a_ready, (g % 2) == 0);
            tick();
            w = 0;
            while (!bus.o_valid && w < 40) begin
                tick();
                w++;
            end
            chk($sformatf("grant %0d result id", g), bus.o_id, g % 2);
            chk_near($sformatf("grant %0d cos", g), int'(signed'(bus.o_cos)),
                     (g % 2) == 0 ? 65536 : -65536);
            tick();
        end
        bus.i_a_valid = 1'b0;
        bus.i_b_valid = 1'b0;
        chk("never both ready", both_seen, 0);

        // Consumer stalls 5 cycles in HOLD while A keeps requesting.
        bus.i_ready   = 1'b0;
        bus.i_a_phase = 18'h10000;
        bus.i_a_valid = 1'b1;
        #1;
        wait_ready(1'b0);
        tick();
        w = 0;
        while (!bus.o_valid && w < 40) begin
            tick();
            w++;
        end
        chk("hold o_valid", bus.o_valid, 1);
        c  = int'(signed'(bus.o_cos));
        s  = int'(signed'(bus.o_sin));
        id = int'(bus.o_id);
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (int'(signed'(bus.o_cos)) != c || int'(signed'(bus.o_sin)) != s ||
                int'(bus.o_id) != id || !bus.o_valid || bus.o_a_ready || bus.o_b_ready)
                stable = 1'b0;
        end
        chk("hold outputs stable", stable, 1);
        chk_near("hold cos", c, 0);
        chk_near("hold sin", s, 65536);
        chk("hold id", id, 0);
        bus.i_ready = 1'b1;
        #1;
        chk("no ready before handshake", bus.o_a_ready, 0);
        tick();
        chk("idle after handshake valid", bus.o_valid, 0);
        chk("idle after handshake ready", bus.o_a_ready, 1);
        bus.i_a_valid = 1'b0;

        // Reset pulsed mid-RUN, then a fresh job must be clean.
        bus.i_b_phase = 18'h2AAAB;
        bus.i_b_valid = 1'b1;
        #1;
        wait_ready(1'b1);
        tick();
        bus.i_b_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        #2 rst = 1'b1;
        #1;
        chk("midrst eng_rst_n", bus.o_eng_rst_n, 0);
        chk("midrst o_valid", bus.o_valid, 0);
        chk("midrst eng_atan", bus.o_eng_atan, 0);
        chk("midrst eng_quadrant", bus.o_eng_quadrant, 0);
        chk("midrst o_id", bus.o_id, 0);
        chk("midrst o_sin", bus.o_sin, 0);
        tick();
        tick();
        rst   = 1'b0;
        stale = 1'b0;
        for (int k = 0; k < 24; k++) begin
            tick();
            if (bus.o_valid) stale = 1'b1;
        end
        chk("no stale o_valid", stale, 0);
        run_job(1'b0, 18'h2AAAB, 1'b0, c, s, id, lat);
        chk_near("post-reset cos", c, -32768);
        chk_near("post-reset sin", s, -56756);
        chk("post-reset id", id, 0);
        chk("post-reset latency", lat, NPE + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
